// File: rtl/l2_writeback_memory_interface.sv
// L2 front end to main memory: read misses, a write-back FIFO that drains in the background, and forwarding from that FIFO.
// Compile-time option: `define WB_COALESCE_EN merges an eviction into an already-buffered entry with the same address.
module l2_writeback_memory_interface #(
    parameter int ADDR_W   = 16,  // MAIN_MEMORY_ADDRESS_WIDTH
    parameter int DATA_W   = 32,  // MAIN_MEMORY_DATA_WIDTH
    parameter int WB_DEPTH = 4    // power of two, >= 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              l2_read_request,
    input  logic [ADDR_W-1:0] l2_read_address,
    output logic [DATA_W-1:0] l2_read_data,
    output logic              l2_read_valid,
    input  logic              l2_evict_valid,
    input  logic [ADDR_W-1:0] l2_evict_address,
    input  logic [DATA_W-1:0] l2_evict_data,
    output logic              l2_evict_ready,
    output logic              wb_empty,
    output logic              main_memory_read_request,
    output logic              main_memory_write_request,
    output logic [ADDR_W-1:0] main_memory_address,
    output logic [DATA_W-1:0] main_memory_write_data,
    input  logic [DATA_W-1:0] main_memory_read_data,
    input  logic              main_memory_ready
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WB_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUE,
        WR_ISSUE,
        RESP
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] fifo_addr [WB_DEPTH];
    logic [DATA_W-1:0] fifo_data [WB_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              merge_hit;
    logic [PTR_W-1:0]  merge_idx;
    logic              accept;
    logic              push;
    logic              pop;

    // Scan oldest to newest so the last match, the newest entry, wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (CNT_W'(i) < count && fifo_addr[head + PTR_W'(i)] == l2_read_address) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data[head + PTR_W'(i)];
            end
        end
    end

`ifdef WB_COALESCE_EN
    // The head entry is excluded while it is being written out, so a new eviction to it appends instead.
    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (CNT_W'(i) < count && !(i == 0 && state == WR_ISSUE) &&
                fifo_addr[head + PTR_W'(i)] == l2_evict_address) begin
                merge_hit = 1'b1;
                merge_idx = head + PTR_W'(i);
            end
        end
    end

    assign l2_evict_ready = (count < FULL_CNT) || merge_hit;
`else
    assign merge_hit      = 1'b0;
    assign merge_idx      = '0;
    assign l2_evict_ready = (count < FULL_CNT);
`endif

    assign wb_empty = (count == '0);
    assign accept   = l2_evict_valid && l2_evict_ready;
    assign push     = accept && !merge_hit;
    assign pop      = (state == WR_ISSUE) && main_memory_ready;

    // NOTE: the entry storage is not reset; count alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[tail] <= l2_evict_address;
            fifo_data[tail] <= l2_evict_data;
        end else if (accept) begin
            fifo_data[merge_idx] <= l2_evict_data;
        end
    end

    // NOTE: all state here is updated with <= so every branch sees the values from before this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                     <= IDLE;
            head                      <= '0;
            tail                      <= '0;
            count                     <= '0;
            l2_read_data              <= '0;
            l2_read_valid             <= 1'b0;
            main_memory_read_request  <= 1'b0;
            main_memory_write_request <= 1'b0;
            main_memory_address       <= '0;
            main_memory_write_data    <= '0;
        end else begin
            l2_read_valid <= 1'b0;

            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;

            unique case (state)
                IDLE: begin
                    // An accepted eviction blocks every other decision this cycle.
                    if (accept) begin
                        state <= IDLE;
                    end else if (l2_read_request && fwd_hit) begin
                        l2_read_data  <= fwd_data;
                        l2_read_valid <= 1'b1;
                        state         <= RESP;
                    end else if (count == FULL_CNT || (!l2_read_request && count != '0)) begin
                        main_memory_write_request <= 1'b1;
                        main_memory_address       <= fifo_addr[head];
                        main_memory_write_data    <= fifo_data[head];
                        state                     <= WR_ISSUE;
                    end else if (l2_read_request) begin
                        main_memory_read_request <= 1'b1;
                        main_memory_address      <= l2_read_address;
                        state                    <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    if (main_memory_ready) begin
                        l2_read_data             <= main_memory_read_data;
                        l2_read_valid            <= 1'b1;
                        main_memory_read_request <= 1'b0;
                        main_memory_address      <= '0;
                        state                    <= RESP;
                    end
                end
                WR_ISSUE: begin
                    if (main_memory_ready) begin
                        main_memory_write_request <= 1'b0;
                        main_memory_address       <= '0;
                        main_memory_write_data    <= '0;
                        state                     <= IDLE;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        !(main_memory_read_request && main_memory_write_request));
    assert property (@(posedge clk) disable iff (reset) count <= FULL_CNT);

endmodule

// File: tb/tb_l2_writeback_memory_interface.sv
// Directed bench for l2_writeback_memory_interface with a one-wait-state main memory model.
module tb_l2_writeback_memory_interface;

    logic        clk = 1'b0;
    logic        reset;
    logic        l2_read_request;
    logic [15:0] l2_read_address;
    logic [31:0] l2_read_data;
    logic        l2_read_valid;
    logic        l2_evict_valid;
    logic [15:0] l2_evict_address;
    logic [31:0] l2_evict_data;
    logic        l2_evict_ready;
    logic        wb_empty;
    logic        mm_rd;
    logic        mm_wr;
    logic [15:0] mm_addr;
    logic [31:0] mm_wdata;
    logic [31:0] mm_rdata = '0;
    logic        mm_ready = 1'b0;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    l2_writeback_memory_interface dut (
        .clk                       (clk),
        .reset                     (reset),
        .l2_read_request           (l2_read_request),
        .l2_read_address           (l2_read_address),
        .l2_read_data              (l2_read_data),
        .l2_read_valid             (l2_read_valid),
        .l2_evict_valid            (l2_evict_valid),
        .l2_evict_address          (l2_evict_address),
        .l2_evict_data             (l2_evict_data),
        .l2_evict_ready            (l2_evict_ready),
        .wb_empty                  (wb_empty),
        .main_memory_read_request  (mm_rd),
        .main_memory_write_request (mm_wr),
        .main_memory_address       (mm_addr),
        .main_memory_write_data    (mm_wdata),
        .main_memory_read_data     (mm_rdata),
        .main_memory_ready         (mm_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Memory model: ready pulses in the second cycle of each request.
    logic [31:0] mem [256];
    bit          mem_written [256];
    logic [15:0] wlog_addr [$];
    logic [31:0] wlog_data [$];
    int          wlog_cyc [$];
    int          rd_starts = 0;
    int          rd_start_writes = 0;
    int          age = 0;

    function automatic logic [31:0] backing(input logic [7:0] a);
        case (a)
            8'h10:   return 32'hDEADBEEF;
            8'h50:   return 32'hCAFEF00D;
            8'h80:   return 32'h80808080;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mem_rd(input logic [7:0] a);
        return mem_written[a] ? mem[a] : backing(a);
    endfunction

    always @(negedge clk) begin
        if (reset || !(mm_rd || mm_wr)) begin
            age      = 0;
            mm_ready = 1'b0;
            mm_rdata = '0;
        end else begin
            age++;
            if (age == 1 && mm_rd) begin
                rd_starts++;
                rd_start_writes = wlog_addr.size();
            end
            if (age == 2) begin
                mm_ready = 1'b1;
                if (mm_rd) begin
                    mm_rdata = mem_rd(mm_addr[7:0]);
                end else begin
                    mem[mm_addr[7:0]]         = mm_wdata;
                    mem_written[mm_addr[7:0]] = 1'b1;
                    wlog_addr.push_back(mm_addr);
                    wlog_data.push_back(mm_wdata);
                    wlog_cyc.push_back(cyc);
                end
            end else begin
                mm_ready = 1'b0;
                mm_rdata = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_empty(input string tag, input int budget);
        for (int i = 0; i < budget && !wb_empty; i++) tick();
        check(tag, 64'(wb_empty), 64'd1);
    endtask

    task automatic evict(input logic [15:0] a, input logic [31:0] d);
        l2_evict_valid   = 1'b1;
        l2_evict_address = a;
        l2_evict_data    = d;
        tick();
        l2_evict_valid   = 1'b0;
    endtask

    initial begin
        int base;
        int exp_writes;
        bit seen_valid;

        reset            = 1'b1;
        l2_read_request  = 1'b0;
        l2_read_address  = '0;
        l2_evict_valid   = 1'b0;
        l2_evict_address = '0;
        l2_evict_data    = '0;
        repeat (2) tick();

        // Reset values.
        check("rst_read_valid", 64'(l2_read_valid), 64'd0);
        check("rst_read_data", 64'(l2_read_data), 64'd0);
        check("rst_evict_ready", 64'(l2_evict_ready), 64'd1);
        check("rst_wb_empty", 64'(wb_empty), 64'd1);
        check("rst_mm_req", 64'({mm_rd, mm_wr}), 64'd0);
        check("rst_mm_addr_data", 64'({mm_addr, mm_wdata}), 64'd0);
        reset = 1'b0;
        tick();

        // 1: read miss, 2 request cycles, valid 3 cycles after sampling.
        l2_read_request = 1'b1;
        l2_read_address = 16'h0010;
        tick();
        check("t1_rdreq_c1", 64'(mm_rd), 64'd1);
        check("t1_mm_addr", 64'(mm_addr), 64'h10);
        check("t1_valid_c1", 64'(l2_read_valid), 64'd0);
        tick();
        check("t1_rdreq_c2", 64'(mm_rd), 64'd1);
        check("t1_valid_c2", 64'(l2_read_valid), 64'd0);
        tick();
        check("t1_rdreq_c3", 64'(mm_rd), 64'd0);
        check("t1_valid_c3", 64'(l2_read_valid), 64'd1);
        check("t1_data", 64'(l2_read_data), 64'hDEADBEEF);
        check("t1_mm_addr_idle", 64'(mm_addr), 64'd0);
        l2_read_request = 1'b0;
        l2_read_address = '0;
        tick();
        check("t1_valid_one_cycle", 64'(l2_read_valid), 64'd0);

        // 2: forwarded hit from a pending eviction.
        check("t2_evict_ready", 64'(l2_evict_ready), 64'd1);
        evict(16'h0020, 32'h11111111);
        check("t2_not_empty", 64'(wb_empty), 64'd0);
        base = rd_starts;
        l2_read_request = 1'b1;
        l2_read_address = 16'h0020;
        tick();
        check("t2_valid", 64'(l2_read_valid), 64'd1);
        check("t2_data", 64'(l2_read_data), 64'h11111111);
        check("t2_no_mm_read", 64'(rd_starts - base), 64'd0);
        l2_read_request = 1'b0;
        wait_empty("t2_drained", 20);
        check("t2_mem", 64'(mem_rd(8'h20)), 64'h11111111);

        // 3: fill four entries, then drain in order, one per 3 cycles.
        base = wlog_addr.size();
        for (int i = 0; i < 4; i++) begin
            check("t3_ready_before_full", 64'(l2_evict_ready), 64'd1);
            evict(16'h0040 + 16'(i), 32'h40000000 + 32'(i));
        end
        check("t3_full_ready", 64'(l2_evict_ready), 64'd0);
        repeat (3) tick();
        check("t3_ready_after_pop", 64'(l2_evict_ready), 64'd1);
        repeat (8) tick();
        check("t3_empty_at_11", 64'(wb_empty), 64'd0);
        tick();
        check("t3_empty_at_12", 64'(wb_empty), 64'd1);
        check("t3_write_count", 64'(wlog_addr.size() - base), 64'd4);
        if (wlog_addr.size() - base == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t3_wr_addr", 64'(wlog_addr[base + i]), 64'h40 + 64'(i));
                check("t3_wr_data", 64'(wlog_data[base + i]), 64'h40000000 + 64'(i));
                if (i > 0) check("t3_wr_spacing", 64'(wlog_cyc[base + i] - wlog_cyc[base + i - 1]), 64'd3);
            end
        end

        // 4: full buffer drains one entry before a read miss is issued.
        for (int i = 0; i < 4; i++) evict(16'h0060 + 16'(i), 32'h60000000 + 32'(i));
        base = wlog_addr.size();
        l2_read_request = 1'b1;
        l2_read_address = 16'h0050;
        for (int i = 0; i < 40 && !l2_read_valid; i++) tick();
        check("t4_valid", 64'(l2_read_valid), 64'd1);
        check("t4_data", 64'(l2_read_data), 64'hCAFEF00D);
        check("t4_writes_before_read", 64'(rd_start_writes - base), 64'd1);
        l2_read_request = 1'b0;
        wait_empty("t4_drained", 40);
        check("t4_total_writes", 64'(wlog_addr.size() - base), 64'd4);

        // 5: two evictions to one address; read returns the newest.
        base = wlog_addr.size();
        evict(16'h0030, 32'h0000000A);
        evict(16'h0030, 32'h0000000B);
        l2_read_request = 1'b1;
        l2_read_address = 16'h0030;
        tick();
        check("t5_valid", 64'(l2_read_valid), 64'd1);
        check("t5_data", 64'(l2_read_data), 64'hB);
        l2_read_request = 1'b0;
        wait_empty("t5_drained", 30);
        check("t5_mem", 64'(mem_rd(8'h30)), 64'hB);
`ifdef WB_COALESCE_EN
        exp_writes = 1;
`else
        exp_writes = 2;
`endif
        check("t5_write_count", 64'(wlog_addr.size() - base), 64'(exp_writes));
        check("t5_last_write", 64'(wlog_data[wlog_data.size() - 1]), 64'hB);

        // 6: reset during RD_ISSUE.
        evict(16'h0070, 32'h77777777);
        l2_read_request = 1'b1;
        l2_read_address = 16'h0080;
        tick();
        check("t6_in_rd_issue", 64'(mm_rd), 64'd1);
        check("t6_not_empty", 64'(wb_empty), 64'd0);
        base = wlog_addr.size();
        reset = 1'b1;
        #1;
        check("t6_rdreq_dropped", 64'(mm_rd), 64'd0);
        check("t6_wb_empty", 64'(wb_empty), 64'd1);
        check("t6_evict_ready", 64'(l2_evict_ready), 64'd1);
        l2_read_request = 1'b0;
        seen_valid = 1'b0;
        repeat (2) begin
            tick();
            seen_valid |= l2_read_valid;
        end
        reset = 1'b0;
        repeat (6) begin
            tick();
            seen_valid |= l2_read_valid;
        end
        check("t6_no_valid_pulse", 64'(seen_valid), 64'd0);
        check("t6_no_writes", 64'(wlog_addr.size() - base), 64'd0);
        check("t6_entry_discarded", 64'(mem_written[8'h70]), 64'd0);
        check("t6_idle_req", 64'({mm_rd, mm_wr}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/l2_writeback_memory_interface.md
Name: l2_writeback_memory_interface

Overview:
- Sits between the L2 cache and main_memory_controller; it is the only master of the main memory request port.
- Services L2 read misses as single-word main memory reads.
- Buffers dirty L2 evictions in a WB_DEPTH-entry write-back FIFO and drains them to main memory in the background.
- Forwards buffered data to reads that hit a pending eviction, so the L2 never sees stale data.

Parameters:
- ADDR_W, default MAIN_MEMORY_ADDRESS_WIDTH (main_memory_config): word address width.
- DATA_W, default MAIN_MEMORY_DATA_WIDTH (main_memory_config): data word width.
- WB_DEPTH, default 4: write-back FIFO entries, power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- l2_read_request  in  1  level; held until l2_read_valid.
- l2_read_address  in  ADDR_W  stable while l2_read_request is high.
- l2_read_data  out  DATA_W  read response data.
- l2_read_valid  out  1  one-cycle response pulse.
- l2_evict_valid  in  1  eviction offered.
- l2_evict_address  in  ADDR_W  eviction address.
- l2_evict_data  in  DATA_W  eviction data.
- l2_evict_ready  out  1  eviction accepted when valid and ready are both high.
- wb_empty  out  1  FIFO holds no entries.
- main_memory_read_request  out  1  to controller.
- main_memory_write_request  out  1  to controller.
- main_memory_address  out  ADDR_W  to controller.
- main_memory_write_data  out  DATA_W  to controller.
- main_memory_read_data  in  DATA_W  from controller; valid while main_memory_ready is high.
- main_memory_ready  in  1  from controller; one-cycle completion pulse.

Behaviour:
- Reset (async, active-high): state IDLE, FIFO count 0, pointers 0.
  - Every output is 0 except wb_empty=1 and l2_evict_ready=1.
  - Reset mid-operation drops main memory requests immediately, discards buffered entries and cancels any pending response.
- FIFO: circular buffer with head/tail pointers that wrap modulo WB_DEPTH; count runs 0..WB_DEPTH.
  - l2_evict_ready = (count < WB_DEPTH); it is independent of state.
  - Acceptance writes the tail; a push and a pop in the same cycle leave count unchanged.
- Forwarding compare uses registered FIFO contents only. The newest valid matching entry wins.
- FSM states: IDLE, RD_ISSUE, WR_ISSUE, RESP.
- IDLE, priority order:
  1. An eviction handshake this cycle: accept it, stay IDLE. No other decision is made this cycle, which closes the same-cycle read/evict hazard.
  2. Read pending and FIFO hit: load l2_read_data with the entry's data, go to RESP.
  3. count == WB_DEPTH: go to WR_ISSUE. A full buffer drains before a read miss.
  4. Read pending: latch the address, go to RD_ISSUE.
  5. count > 0: go to WR_ISSUE.
  6. Otherwise stay IDLE.
- RD_ISSUE:
  - main_memory_read_request=1; main_memory_address holds the latched address.
  - On main_memory_ready: capture main_memory_read_data into l2_read_data, go to RESP.
- WR_ISSUE:
  - main_memory_write_request=1; address and data come from the FIFO head and stay stable.
  - On main_memory_ready: pop the head, go to IDLE.
- RESP: l2_read_valid=1 for exactly one cycle, then go to IDLE. The L2 drops or changes the request after this pulse.
- Main memory requests are never asserted together.
  - Address and write data are 0 when no request is active.
  - A request is held until main_memory_ready and is deasserted in the cycle after ready.
- Latency:
  - Read miss: l2_read_valid 3 cycles after IDLE samples the request (RD_ISSUE, ready, RESP).
  - Forwarded hit: 1 cycle.
  - Drain: 3 cycles per entry.
- Evictions are accepted in every state when not full. The L2 never evicts the address of its own outstanding read miss.
- wb_empty = (count == 0).

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined: an eviction whose address matches a valid FIFO entry overwrites that entry's data in place; count is unchanged and drain order is unchanged.
  - l2_evict_ready stays 1 when full if the offered address matches an entry.
  - An entry currently in WR_ISSUE is excluded from matching, so its eviction appends instead.
- Undefined: every eviction appends; duplicate addresses drain in order, oldest first.

Test Plan:
1. After reset, memory[0x0010]=0xDEADBEEF; read 0x0010 → main_memory_read_request high for 2 cycles; l2_read_valid pulses 3 cycles after sampling, with data 0xDEADBEEF.
2. Evict 0x0020/0x11111111, then read 0x0020 → l2_read_valid 1 cycle later with 0x11111111; no main_memory_read_request during the read.
3. Four back-to-back evictions 0x40..0x43, no reads → l2_evict_ready low after the 4th; writes reach memory in order, one per 3 cycles; wb_empty=1 after 12 cycles.
4. FIFO full and read miss to 0x0050 → exactly one write completes before main_memory_read_request rises; the read returns correct data.
5. Evict 0x0030=0xA then 0x0030=0xB, then read 0x0030 → returns 0xB; after drain memory[0x30]=0xB. With WB_COALESCE_EN: count=1 and a single write occurs.
6. Reset asserted during RD_ISSUE → main_memory_read_request low in the same cycle; no l2_read_valid pulse; wb_empty=1; l2_evict_ready=1.
